// File: rtl/cprv_mem_arbiter.sv
// cprv_mem_arbiter: shares one memory port between the instruction-fetch (IF)
// and data-memory (DM) requesters. One transaction is in flight at a time;
// grants rotate round-robin when both sides request in the same cycle, and
// the registered memory response is returned only to the owning requester.
module cprv_mem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // IF requester
    input  logic                  valid_if_i,
    output logic                  ready_if_o,
    input  logic [ADDR_WIDTH-1:0] addr_if_i,
    output logic                  valid_if_o,
    input  logic                  ready_if_i,
    output logic [DATA_WIDTH-1:0] rdata_if_o,
    // DM requester
    input  logic                  valid_dm_i,
    output logic                  ready_dm_o,
    input  logic [ADDR_WIDTH-1:0] addr_dm_i,
    input  logic [DATA_WIDTH-1:0] wdata_dm_i,
    input  logic                  w_en_dm_i,
    output logic                  valid_dm_o,
    input  logic                  ready_dm_i,
    output logic [DATA_WIDTH-1:0] rdata_dm_o,
    // memory port
    output logic                  valid_mem_o,
    input  logic                  ready_mem_i,
    output logic [ADDR_WIDTH-1:0] addr_mem_o,
    output logic [DATA_WIDTH-1:0] wdata_mem_o,
    output logic                  w_en_mem_o,
    input  logic                  valid_mem_i,
    output logic                  ready_mem_o,
    input  logic [DATA_WIDTH-1:0] rdata_mem_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RESP    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    // Requester identity used for owner and last_grant.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  w_en_q, w_en_d;
    logic [DATA_WIDTH-1:0] rdata_if_q, rdata_if_d;
    logic [DATA_WIDTH-1:0] rdata_dm_q, rdata_dm_d;

    logic grant_if;
    logic grant_dm;
    logic owner_ready;

    // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_if = valid_if_i & (~valid_dm_i | (last_grant_q == OWN_DM));
        grant_dm = valid_dm_i & (~valid_if_i | (last_grant_q == OWN_IF));
    end

    // Next-state logic and handshake outputs of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        w_en_d       = w_en_q;
        rdata_if_d   = rdata_if_q;
        rdata_dm_d   = rdata_dm_q;
        ready_if_o   = 1'b0;
        ready_dm_o   = 1'b0;
        valid_mem_o  = 1'b0;
        ready_mem_o  = 1'b0;
        valid_if_o   = 1'b0;
        valid_dm_o   = 1'b0;
        owner_ready  = (owner_q == OWN_IF) ? ready_if_i : ready_dm_i;

        unique case (state_q)
            IDLE: begin
                ready_if_o = grant_if;
                ready_dm_o = grant_dm;
                if (grant_if) begin
                    // Fetches are always reads with zero store data.
                    addr_d       = addr_if_i;
                    wdata_d      = '0;
                    w_en_d       = 1'b0;
                    owner_d      = OWN_IF;
                    last_grant_d = OWN_IF;
                    state_d      = REQ;
                end else if (grant_dm) begin
                    addr_d       = addr_dm_i;
                    wdata_d      = wdata_dm_i;
                    w_en_d       = w_en_dm_i;
                    owner_d      = OWN_DM;
                    last_grant_d = OWN_DM;
                    state_d      = REQ;
                end
            end
            REQ: begin
                valid_mem_o = 1'b1;
                if (ready_mem_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ready_mem_o = 1'b1;
                if (valid_mem_i) begin
                    if (owner_q == OWN_IF) begin
                        rdata_if_d = rdata_mem_i;
                    end else begin
                        rdata_dm_d = rdata_mem_i;
                    end
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                valid_if_o = (owner_q == OWN_IF);
                valid_dm_o = (owner_q == OWN_DM);
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset leaves IF as the first winner of a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_DM;
            addr_q       <= '0;
            wdata_q      <= '0;
            w_en_q       <= 1'b0;
            rdata_if_q   <= '0;
            rdata_dm_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            w_en_q       <= w_en_d;
            rdata_if_q   <= rdata_if_d;
            rdata_dm_q   <= rdata_dm_d;
        end
    end

    // Memory request fields and response data come straight from registers.
    always_comb begin
        addr_mem_o  = addr_q;
        wdata_mem_o = wdata_q;
        w_en_mem_o  = w_en_q;
        rdata_if_o  = rdata_if_q;
        rdata_dm_o  = rdata_dm_q;
    end

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Testbench for cprv_mem_arbiter: directed latency/reset/spurious-response
// checks plus a randomized phase with two requester drivers, a memory model
// and a scoreboard monitor.
module tb_cprv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_if_i, ready_if_o, valid_if_o, ready_if_i;
    logic [63:0] addr_if_i, rdata_if_o;
    logic        valid_dm_i, ready_dm_o, w_en_dm_i, valid_dm_o, ready_dm_i;
    logic [63:0] addr_dm_i, wdata_dm_i, rdata_dm_o;
    logic        valid_mem_o, ready_mem_i, w_en_mem_o, valid_mem_i, ready_mem_o;
    logic [63:0] addr_mem_o, wdata_mem_o, rdata_mem_i;

    cprv_mem_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_if_i(valid_if_i), .ready_if_o(ready_if_o), .addr_if_i(addr_if_i),
        .valid_if_o(valid_if_o), .ready_if_i(ready_if_i), .rdata_if_o(rdata_if_o),
        .valid_dm_i(valid_dm_i), .ready_dm_o(ready_dm_o), .addr_dm_i(addr_dm_i),
        .wdata_dm_i(wdata_dm_i), .w_en_dm_i(w_en_dm_i), .valid_dm_o(valid_dm_o),
        .ready_dm_i(ready_dm_i), .rdata_dm_o(rdata_dm_o),
        .valid_mem_o(valid_mem_o), .ready_mem_i(ready_mem_i), .addr_mem_o(addr_mem_o),
        .wdata_mem_o(wdata_mem_o), .w_en_mem_o(w_en_mem_o), .valid_mem_i(valid_mem_i),
        .ready_mem_o(ready_mem_o), .rdata_mem_i(rdata_mem_i)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard queues filled by the drivers at acceptance time.
    logic [63:0] exp_if_q[$];
    logic [63:0] exp_if_addr_q[$];
    logic [63:0] exp_dm_q[$];
    logic [63:0] exp_dm_addr_q[$];

    // Reference view of data memory (DM is the only writer) and the memory model's storage.
    logic [63:0] ref_dm[logic [63:0]];
    logic [63:0] mem_arr[logic [63:0]];

    bit          drivers_done = 0;
    bit          stop_all = 0;
    bit          busy = 0;
    bit          last_g = 0;       // 1: last grant went to DM
    logic [63:0] cur_addr = '0;
    logic [63:0] cur_wdata = '0;
    logic        cur_wen = 1'b0;

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired", name);
    endtask

    // IF driver: random fetch addresses, occasional withdrawal before acceptance.
    task automatic if_driver(input int n);
        for (int t = 0; t < n; t++) begin
            logic [63:0] a;
            bit done;
            int wait_cnt;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = 64'h1000 + 64'(8 * $urandom_range(0, 63));
            done = 0;
            wait_cnt = 0;
            valid_if_i = 1'b1;
            addr_if_i = a;
            while (!done) begin
                @(negedge clk);
                if (ready_if_o) begin
                    exp_if_q.push_back(init_val(a));
                    exp_if_addr_q.push_back(a);
                    done = 1;
                end else if (++wait_cnt > 300) begin
                    fail_now("if_accept_wait");
                    done = 1;
                end
                @(posedge clk); #1;
                if (done) begin
                    valid_if_i = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    valid_if_i = 1'b0;
                    @(posedge clk); #1;
                    valid_if_i = 1'b1;
                end
            end
        end
    endtask

    // DM driver: random loads/stores in a small region so reads hit earlier stores.
    task automatic dm_driver(input int n);
        for (int t = 0; t < n; t++) begin
            logic [63:0] a, wd;
            logic we;
            bit done;
            int wait_cnt;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = 64'h2000 + 64'(8 * $urandom_range(0, 15));
            wd = {$urandom, $urandom};
            we = 1'($urandom_range(0, 1));
            done = 0;
            wait_cnt = 0;
            valid_dm_i = 1'b1;
            addr_dm_i = a;
            wdata_dm_i = wd;
            w_en_dm_i = we;
            while (!done) begin
                @(negedge clk);
                if (ready_dm_o) begin
                    if (we) begin
                        ref_dm[a] = wd;
                        exp_dm_q.push_back(64'h0);
                    end else begin
                        exp_dm_q.push_back(ref_dm.exists(a) ? ref_dm[a] : init_val(a));
                    end
                    exp_dm_addr_q.push_back(a);
                    done = 1;
                end else if (++wait_cnt > 300) begin
                    fail_now("dm_accept_wait");
                    done = 1;
                end
                @(posedge clk); #1;
                if (done) begin
                    valid_dm_i = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    valid_dm_i = 1'b0;
                    @(posedge clk); #1;
                    valid_dm_i = 1'b1;
                end
            end
        end
    endtask

    // Memory model with random request/response stalls and spurious responses while idle.
    task automatic mem_model();
        bit phase = 0;
        logic [63:0] resp = '0;
        while (!stop_all) begin
            ready_if_i = ($urandom_range(0, 2) != 0);
            ready_dm_i = ($urandom_range(0, 2) != 0);
            if (!phase) begin
                ready_mem_i = ($urandom_range(0, 2) != 0);
                valid_mem_i = ($urandom_range(0, 7) == 0);
                rdata_mem_i = {$urandom, $urandom};
            end else begin
                ready_mem_i = 1'b0;
                valid_mem_i = 1'($urandom_range(0, 1));
                rdata_mem_i = resp;
            end
            @(negedge clk);
            chk("ready_mem_o", 64'(ready_mem_o), 64'(phase));
            if (!phase && valid_mem_o && ready_mem_i) begin
                chk("mem_addr", addr_mem_o, cur_addr);
                chk("mem_wdata", wdata_mem_o, cur_wdata);
                chk("mem_w_en", 64'(w_en_mem_o), 64'(cur_wen));
                if (w_en_mem_o) begin
                    mem_arr[addr_mem_o] = wdata_mem_o;
                    resp = '0;
                end else begin
                    resp = mem_arr.exists(addr_mem_o) ? mem_arr[addr_mem_o] : init_val(addr_mem_o);
                end
                phase = 1;
            end else if (phase && valid_mem_i && ready_mem_o) begin
                phase = 0;
            end
            @(posedge clk); #1;
        end
        valid_mem_i = 1'b0;
        ready_mem_i = 1'b0;
        ready_if_i = 1'b0;
        ready_dm_i = 1'b0;
    endtask

    // Monitor: arbitration rule, hold-stability and scoreboard comparison of responses.
    task automatic monitor();
        int cyc = 0;
        bit mem_hold = 0, if_hold = 0, dm_hold = 0;
        logic [63:0] p_addr = '0, p_wd = '0, p_if = '0, p_dm = '0;
        logic p_wen = 1'b0;
        logic exp_rif, exp_rdm;
        logic [63:0] e, a;
        while (!stop_all) begin
            @(negedge clk);
            cyc++;
            exp_rif = !busy && valid_if_i && (!valid_dm_i || last_g);
            exp_rdm = !busy && valid_dm_i && (!valid_if_i || !last_g);
            chk("ready_if_o", 64'(ready_if_o), 64'(exp_rif));
            chk("ready_dm_o", 64'(ready_dm_o), 64'(exp_rdm));

            if (mem_hold) begin
                chk("mem_hold_valid", 64'(valid_mem_o), 64'h1);
                chk("mem_hold_addr", addr_mem_o, p_addr);
                chk("mem_hold_wdata", wdata_mem_o, p_wd);
                chk("mem_hold_w_en", 64'(w_en_mem_o), 64'(p_wen));
            end
            mem_hold = valid_mem_o && !ready_mem_i;
            p_addr = addr_mem_o; p_wd = wdata_mem_o; p_wen = w_en_mem_o;

            if (if_hold) begin
                chk("if_hold_valid", 64'(valid_if_o), 64'h1);
                chk("if_hold_rdata", rdata_if_o, p_if);
            end
            if (dm_hold) begin
                chk("dm_hold_valid", 64'(valid_dm_o), 64'h1);
                chk("dm_hold_rdata", rdata_dm_o, p_dm);
            end

            if (valid_if_o) begin
                chk("if_dm_exclusive", 64'(valid_dm_o), 64'h0);
                if (ready_if_i) begin
                    if (exp_if_q.size() == 0) begin
                        fail_now("if_unexpected_response");
                    end else begin
                        e = exp_if_q.pop_front();
                        a = exp_if_addr_q.pop_front();
                        chk("rdata_if", rdata_if_o, e);
                        $display("txn IF  rd addr=%h rdata=%h", a, rdata_if_o);
                    end
                    busy = 0;
                end
            end else if (valid_dm_o) begin
                if (ready_dm_i) begin
                    if (exp_dm_q.size() == 0) begin
                        fail_now("dm_unexpected_response");
                    end else begin
                        e = exp_dm_q.pop_front();
                        a = exp_dm_addr_q.pop_front();
                        chk("rdata_dm", rdata_dm_o, e);
                        $display("txn DM    addr=%h rdata=%h", a, rdata_dm_o);
                    end
                    busy = 0;
                end
            end
            if_hold = valid_if_o && !ready_if_i;
            dm_hold = valid_dm_o && !ready_dm_i;
            p_if = rdata_if_o; p_dm = rdata_dm_o;

            if (exp_rif) begin
                busy = 1; last_g = 0;
                cur_addr = addr_if_i; cur_wdata = '0; cur_wen = 1'b0;
            end else if (exp_rdm) begin
                busy = 1; last_g = 1;
                cur_addr = addr_dm_i; cur_wdata = wdata_dm_i; cur_wen = w_en_dm_i;
            end

            if (drivers_done && !busy) begin
                stop_all = 1;
            end else if (cyc > 30000) begin
                fail_now("random_phase_timeout");
                stop_all = 1;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready_if_o"}, 64'(ready_if_o), 64'h0);
        chk({tag, "_ready_dm_o"}, 64'(ready_dm_o), 64'h0);
        chk({tag, "_valid_if_o"}, 64'(valid_if_o), 64'h0);
        chk({tag, "_valid_dm_o"}, 64'(valid_dm_o), 64'h0);
        chk({tag, "_valid_mem_o"}, 64'(valid_mem_o), 64'h0);
        chk({tag, "_ready_mem_o"}, 64'(ready_mem_o), 64'h0);
        chk({tag, "_addr_mem_o"}, addr_mem_o, 64'h0);
        chk({tag, "_wdata_mem_o"}, wdata_mem_o, 64'h0);
        chk({tag, "_w_en_mem_o"}, 64'(w_en_mem_o), 64'h0);
        chk({tag, "_rdata_if_o"}, rdata_if_o, 64'h0);
        chk({tag, "_rdata_dm_o"}, rdata_dm_o, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        valid_if_i = 0; addr_if_i = '0; ready_if_i = 0;
        valid_dm_i = 0; addr_dm_i = '0; wdata_dm_i = '0; w_en_dm_i = 0; ready_dm_i = 0;
        ready_mem_i = 0; valid_mem_i = 0; rdata_mem_i = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Single fetch with an always-ready 1-cycle memory: cycle-exact latency.
        @(posedge clk); #1;
        valid_if_i = 1; addr_if_i = 64'h1000; ready_mem_i = 1; ready_if_i = 1;
        @(negedge clk);
        chk("c0_ready_if_o", 64'(ready_if_o), 64'h1);
        chk("c0_valid_mem_o", 64'(valid_mem_o), 64'h0);
        @(posedge clk); #1;
        valid_if_i = 0;
        @(negedge clk);
        chk("c1_valid_mem_o", 64'(valid_mem_o), 64'h1);
        chk("c1_addr_mem_o", addr_mem_o, 64'h1000);
        chk("c1_w_en_mem_o", 64'(w_en_mem_o), 64'h0);
        chk("c1_ready_if_o", 64'(ready_if_o), 64'h0);
        @(posedge clk); #1;
        valid_mem_i = 1; rdata_mem_i = 64'hDEADBEEF;
        @(negedge clk);
        chk("c2_ready_mem_o", 64'(ready_mem_o), 64'h1);
        chk("c2_valid_mem_o", 64'(valid_mem_o), 64'h0);
        @(posedge clk); #1;
        valid_mem_i = 0; ready_mem_i = 0;
        @(negedge clk);
        chk("c3_valid_if_o", 64'(valid_if_o), 64'h1);
        chk("c3_rdata_if_o", rdata_if_o, 64'hDEADBEEF);
        chk("c3_valid_dm_o", 64'(valid_dm_o), 64'h0);
        @(posedge clk); #1;
        ready_if_i = 0;
        @(negedge clk);
        chk("c4_valid_if_o", 64'(valid_if_o), 64'h0);

        // Randomized traffic; IF was granted last above.
        last_g = 0;
        @(posedge clk); #1;
        fork
            begin
                fork
                    if_driver(40);
                    dm_driver(40);
                join
                drivers_done = 1;
            end
            mem_model();
            monitor();
        join
        chk("if_queue_drained", 64'(exp_if_q.size()), 64'h0);
        chk("dm_queue_drained", 64'(exp_dm_q.size()), 64'h0);
        valid_if_i = 0; valid_dm_i = 0; ready_mem_i = 0; valid_mem_i = 0;
        ready_if_i = 0; ready_dm_i = 0;

        // Spurious memory response while idle must be ignored.
        valid_mem_i = 1; rdata_mem_i = 64'hBADC0FFEE0DDF00D;
        repeat (3) begin
            @(negedge clk);
            chk("spur_ready_mem_o", 64'(ready_mem_o), 64'h0);
            chk("spur_valid_if_o", 64'(valid_if_o), 64'h0);
            chk("spur_valid_dm_o", 64'(valid_dm_o), 64'h0);
            @(posedge clk); #1;
        end
        valid_mem_i = 0;

        // Reset while waiting for the memory response.
        valid_dm_i = 1; addr_dm_i = 64'h2008; wdata_dm_i = 64'h55; w_en_dm_i = 1; ready_mem_i = 1;
        @(negedge clk);
        chk("rr_ready_dm_o", 64'(ready_dm_o), 64'h1);
        @(posedge clk); #1;
        valid_dm_i = 0;
        @(negedge clk);
        chk("rr_valid_mem_o", 64'(valid_mem_o), 64'h1);
        chk("rr_wdata_mem_o", wdata_mem_o, 64'h55);
        @(posedge clk); #1;
        ready_mem_i = 0;
        @(negedge clk);
        chk("rr_ready_mem_o", 64'(ready_mem_o), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid_if_i = 1; addr_if_i = 64'h1100;
        valid_dm_i = 1; addr_dm_i = 64'h2010; w_en_dm_i = 0;
        @(negedge clk);
        chk("after_reset_ready_if_o", 64'(ready_if_o), 64'h1);
        chk("after_reset_ready_dm_o", 64'(ready_dm_o), 64'h0);
        @(posedge clk); #1;
        valid_if_i = 0; valid_dm_i = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cprv_mem_arbiter.md
Name: cprv_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IF) and the mem-stage data requester (DM).
- Valid/ready handshakes on every interface.
- One transaction in flight at a time, with round-robin arbitration.
- Responses are registered and routed back to the requester that owns the transaction.

Parameters:
DATA_WIDTH, 64, width of read/write data
ADDR_WIDTH, 64, width of address

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_if_i  in  1  IF request valid
ready_if_o  out  1  IF request accepted
addr_if_i  in  ADDR_WIDTH  IF fetch address
valid_if_o  out  1  IF response valid
ready_if_i  in  1  IF response ready
rdata_if_o  out  DATA_WIDTH  IF response data
valid_dm_i  in  1  DM request valid
ready_dm_o  out  1  DM request accepted
addr_dm_i  in  ADDR_WIDTH  DM address
wdata_dm_i  in  DATA_WIDTH  DM store data
w_en_dm_i  in  1  DM write enable (1 = store)
valid_dm_o  out  1  DM response valid (load data or store ack)
ready_dm_i  in  1  DM response ready
rdata_dm_o  out  DATA_WIDTH  DM response data
valid_mem_o  out  1  memory request valid
ready_mem_i  in  1  memory request ready
addr_mem_o  out  ADDR_WIDTH  memory address
wdata_mem_o  out  DATA_WIDTH  memory write data
w_en_mem_o  out  1  memory write enable
valid_mem_i  in  1  memory response valid
ready_mem_o  out  1  arbiter ready for memory response
rdata_mem_i  in  DATA_WIDTH  memory response data

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, owner = IF, last_grant = DM.
  - All valid and ready outputs = 0.
  - addr_mem_o, wdata_mem_o, w_en_mem_o, rdata_if_o and rdata_dm_o = 0.
- States: IDLE, REQ, RESP, DELIVER.
- IDLE, grant (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - ready_if_o = (state==IDLE) & grant_if. ready_dm_o = (state==IDLE) & grant_dm. At most one is high.
- IDLE, accept (on a handshake edge):
  - Register addr, wdata and w_en. IF requests always use w_en = 0 and wdata = 0.
  - Set owner and last_grant to the granted requester.
  - Go to REQ.
- REQ: valid_mem_o = 1, outputs driven from registers and held stable. On ready_mem_i = 1, go to RESP.
- RESP: ready_mem_o = 1. On valid_mem_i = 1, capture rdata_mem_i into the owner's rdata register and go to DELIVER.
  - The memory returns exactly one response per request; stores return an ack.
  - valid_mem_i outside RESP is ignored and not acknowledged.
- DELIVER: the owner's valid_x_o = 1 and rdata is held. On the owner's ready_x_i = 1, go to IDLE. The other requester's valid_x_o stays 0.
- Latency, with all counterparties always ready:
  - Request accept at edge 0; valid_mem_o high in cycle 1.
  - A 1-cycle memory gives a response in cycle 2 and valid_x_o in cycle 3.
  - The next accept is at the DELIVER→IDLE edge plus one cycle. Minimum turnaround is 4 cycles per transaction.
- Requests arriving while not IDLE see ready_x_o = 0 and must be held by the requester.
- Fairness: with both requesters continuously valid, grants alternate IF, DM, IF, DM…
- Reset mid-transaction: return immediately to IDLE and drop all valids. The in-flight transaction is lost, and discarding its stale response is the memory's responsibility.
- Deasserting valid_x_i before acceptance is legal. No grant is recorded in that case.

Test Plan:
- Reset, then IF request only (addr = 0x1000), memory ready and responding with 0xDEADBEEF one cycle later → ready_if_o pulses one cycle. valid_mem_o = 1, addr_mem_o = 0x1000, w_en_mem_o = 0. valid_if_o = 1 with rdata_if_o = 0xDEADBEEF. valid_dm_o stays 0.
- Both requesters valid continuously for 4 transactions → grant order IF, DM, IF, DM. No overlap on valid_mem_o transactions.
- DM store (addr = 0x2008, wdata = 0x55, w_en = 1), ready_mem_i held low for 5 cycles → valid_mem_o and addr/wdata/w_en stay stable all 5 cycles. Exactly one accept, then the ack appears on valid_dm_o.
- Response backpressure: ready_if_i low for 3 cycles in DELIVER → valid_if_o and rdata_if_o held. A pending DM request sees ready_dm_o = 0 until DELIVER exits.
- rst_n asserted while in RESP → all outputs 0 asynchronously. After release, a new IF request is granted first.
- Spurious valid_mem_i in IDLE → ignored. ready_mem_o = 0 and no response valid.
